// File: rtl/dp_ram_fifo_ctrl.sv
// First-word-fall-through FIFO controller in front of a dual-port RAM macro.
// The RAM holds the bulk of the queue. A 2-entry skid buffer absorbs the
// 1-cycle RAM read latency, so the head word is presented with no bubbles.
module dp_ram_fifo_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    CLKA,
  input  logic                    rst_n,
  input  logic                    push_valid_i,
  output logic                    push_ready_o,
  input  logic [DATA_WIDTH-1:0]   push_data_i,
  output logic                    pop_valid_o,
  input  logic                    pop_ready_i,
  output logic [DATA_WIDTH-1:0]   pop_data_o,
  output logic [ADDR_WIDTH+1:0]   count_o,
  output logic [ADDR_WIDTH-1:0]   ram_AA_o,
  output logic                    ram_CEA_o,
  output logic [ADDR_WIDTH-1:0]   ram_AB_o,
  output logic                    ram_CEB_o,
  output logic [DATA_WIDTH-1:0]   ram_DB_o,
  output logic [DATA_WIDTH-1:0]   ram_BWB_o,
  input  logic [DATA_WIDTH-1:0]   ram_QA_i
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam int OW    = ADDR_WIDTH + 2;

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         ram_cnt_q, ram_cnt_d;
  logic                  inflight_q, inflight_d;
  logic                  skid_head_q, skid_head_d;
  logic                  skid_tail_q, skid_tail_d;
  logic [1:0]            skid_cnt_q, skid_cnt_d;
  logic [DATA_WIDTH-1:0] skid_mem_q [2];

  logic                  push_fire;
  logic                  pop_fire;
  logic                  rd_issue;
  logic [2:0]            pending;

  // Handshakes and RAM port drive. A read is only issued when its word is
  // guaranteed a skid slot on arrival, counting the word already in flight
  // and any slot freed by a pop this cycle. push_ready_o looks at the RAM
  // occupancy only, so it never depends combinationally on pop_ready_i.
  always_comb begin
    push_ready_o = rst_n && (ram_cnt_q < CW'(DEPTH));
    push_fire    = push_valid_i && push_ready_o;
    pop_valid_o  = (skid_cnt_q != 2'd0);
    pop_fire     = pop_valid_o && pop_ready_i;
    pending      = {1'b0, skid_cnt_q} + {2'b00, inflight_q} - {2'b00, pop_fire};
    rd_issue     = rst_n && (ram_cnt_q != '0) && (pending < 3'd2);
    ram_CEB_o    = push_fire;
    ram_AB_o     = wr_ptr_q;
    ram_DB_o     = push_data_i;
    ram_BWB_o    = '1;
    ram_CEA_o    = rd_issue;
    ram_AA_o     = rd_ptr_q;
    pop_data_o   = skid_mem_q[skid_head_q];
    count_o      = OW'(ram_cnt_q) + OW'(inflight_q) + OW'(skid_cnt_q);
  end

  // Next-state for pointers and occupancy counters.
  always_comb begin
    wr_ptr_d    = push_fire ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
    rd_ptr_d    = rd_issue  ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
    inflight_d  = rd_issue;
    skid_tail_d = skid_tail_q ^ inflight_q;
    skid_head_d = skid_head_q ^ pop_fire;
    ram_cnt_d   = ram_cnt_q;
    case ({push_fire, rd_issue})
      2'b10:   ram_cnt_d = ram_cnt_q + CW'(1);
      2'b01:   ram_cnt_d = ram_cnt_q - CW'(1);
      default: ram_cnt_d = ram_cnt_q;
    endcase
    skid_cnt_d = skid_cnt_q;
    case ({inflight_q, pop_fire})
      2'b10:   skid_cnt_d = skid_cnt_q + 2'd1;
      2'b01:   skid_cnt_d = skid_cnt_q - 2'd1;
      default: skid_cnt_d = skid_cnt_q;
    endcase
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge CLKA) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_cnt_q   <= '0;
      inflight_q  <= 1'b0;
      skid_head_q <= 1'b0;
      skid_tail_q <= 1'b0;
      skid_cnt_q  <= 2'd0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_cnt_q   <= ram_cnt_d;
      inflight_q  <= inflight_d;
      skid_head_q <= skid_head_d;
      skid_tail_q <= skid_tail_d;
      skid_cnt_q  <= skid_cnt_d;
    end
  end

  // Capture returning RAM data into the skid tail; a read still in flight
  // when reset is asserted is dropped.
  always_ff @(posedge CLKA) begin
    if (rst_n && inflight_q) begin
      skid_mem_q[skid_tail_q] <= ram_QA_i;
    end
  end

endmodule

// File: tb/tb_dp_ram_fifo_ctrl.sv
// Bench for dp_ram_fifo_ctrl: RAM model, queue-level reference model with a
// per-cycle compare process, and directed scenarios with literal checks.
module tb_dp_ram_fifo_ctrl;

  logic        CLKA;
  logic        rst_n;
  logic        push_valid_i;
  logic        push_ready_o;
  logic [31:0] push_data_i;
  logic        pop_valid_o;
  logic        pop_ready_i;
  logic [31:0] pop_data_o;
  logic [5:0]  count_o;
  logic [3:0]  ram_AA_o;
  logic        ram_CEA_o;
  logic [3:0]  ram_AB_o;
  logic        ram_CEB_o;
  logic [31:0] ram_DB_o;
  logic [31:0] ram_BWB_o;
  logic [31:0] ram_QA_i;

  int n_checks = 0;
  int n_fail   = 0;

  dp_ram_fifo_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
    .CLKA(CLKA), .rst_n(rst_n),
    .push_valid_i(push_valid_i), .push_ready_o(push_ready_o), .push_data_i(push_data_i),
    .pop_valid_o(pop_valid_o), .pop_ready_i(pop_ready_i), .pop_data_o(pop_data_o),
    .count_o(count_o),
    .ram_AA_o(ram_AA_o), .ram_CEA_o(ram_CEA_o),
    .ram_AB_o(ram_AB_o), .ram_CEB_o(ram_CEB_o),
    .ram_DB_o(ram_DB_o), .ram_BWB_o(ram_BWB_o),
    .ram_QA_i(ram_QA_i)
  );

  initial CLKA = 1'b0;
  always #5 CLKA = ~CLKA;

  // RAM model: 1-cycle read latency; QA carries junk whenever no read was issued.
  logic [31:0] mem [16];
  always @(posedge CLKA) begin
    if (ram_CEB_o) mem[ram_AB_o] <= ram_DB_o;
    if (ram_CEA_o) ram_QA_i <= mem[ram_AA_o];
    else           ram_QA_i <= $urandom;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: q holds every stored word oldest first. The newest m_ram
  // words still sit in RAM, m_fly are being read, the rest are visible.
  logic [31:0] q[$];
  logic [31:0] pop_log[$];
  int m_ram = 0;
  int m_fly = 0;
  int wcnt  = 0;
  int rcnt  = 0;

  initial begin : monitor
    int vis;
    bit exp_pr, pf, pof, iss, en;
    logic [31:0] pd;
    @(posedge CLKA);
    forever begin
      @(negedge CLKA);
      vis    = q.size() - m_ram - m_fly;
      exp_pr = rst_n && (m_ram < 16);
      pf     = push_valid_i && exp_pr;
      pof    = (vis > 0) && pop_ready_i;
      iss    = rst_n && (m_ram > 0) && ((vis + m_fly - int'(pof)) < 2);
      chk("push_ready", push_ready_o, exp_pr);
      chk("pop_valid", pop_valid_o, vis > 0);
      if (vis > 0) chk("pop_data", pop_data_o, q[0]);
      chk("count", count_o, q.size());
      chk("ceb", ram_CEB_o, pf);
      chk("cea", ram_CEA_o, iss);
      chk("bwb", ram_BWB_o, 32'hFFFF_FFFF);
      if (pf) begin
        chk("ab", ram_AB_o, wcnt % 16);
        chk("db", ram_DB_o, push_data_i);
      end
      if (iss) chk("aa", ram_AA_o, rcnt % 16);
      if (ram_CEA_o && ram_CEB_o) chk("collision", ram_AA_o == ram_AB_o, 1'b0);
      pd = push_data_i;
      en = rst_n;
      @(posedge CLKA);
      if (!en) begin
        q.delete();
        m_ram = 0; m_fly = 0; wcnt = 0; rcnt = 0;
      end else begin
        if (pof) begin
          pop_log.push_back(q[0]);
          void'(q.pop_front());
        end
        if (pf) begin
          q.push_back(pd);
          m_ram++;
          wcnt++;
        end
        m_fly = iss ? 1 : 0;
        if (iss) begin
          m_ram--;
          rcnt++;
        end
      end
    end
  end

  task automatic step();
    @(posedge CLKA);
    #1;
  endtask

  // Holds push_valid_i until the word is accepted, bounded to 50 cycles.
  task automatic push_word(input logic [31:0] d);
    int t;
    t = 0;
    push_valid_i = 1'b1;
    push_data_i  = d;
    #1;
    while (!push_ready_o && t < 50) begin
      step();
      t++;
    end
    if (t >= 50) chk("push_timeout", 1'b1, 1'b0);
    step();
    push_valid_i = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    pop_ready_i  = 1'b1;
    push_valid_i = 1'b0;
    while (count_o != 0 && t < 200) begin
      step();
      t++;
    end
    chk(name, count_o, 0);
  endtask

  initial begin
    rst_n = 1'b0; push_valid_i = 1'b0; push_data_i = '0; pop_ready_i = 1'b0;
    repeat (3) step();
    chk("rst_count", count_o, 0);
    chk("rst_pop_valid", pop_valid_o, 0);
    chk("rst_push_ready", push_ready_o, 0);
    chk("rst_cea", ram_CEA_o, 0);

    // Single word: push edge E0, read the next cycle, visible from E2.
    rst_n = 1'b1; pop_ready_i = 1'b1; push_valid_i = 1'b1; push_data_i = 32'hA5A5_0001;
    #1;
    chk("t1_ready", push_ready_o, 1);
    chk("t1_ceb", ram_CEB_o, 1);
    chk("t1_ab", ram_AB_o, 0);
    step();
    push_valid_i = 1'b0;
    #1;
    chk("t1_cnt_e0", count_o, 1);
    chk("t1_cea", ram_CEA_o, 1);
    chk("t1_aa", ram_AA_o, 0);
    step();
    chk("t1_cnt_e1", count_o, 1);
    chk("t1_nvalid_e1", pop_valid_o, 0);
    step();
    chk("t1_valid_e2", pop_valid_o, 1);
    chk("t1_data_e2", pop_data_o, 32'hA5A5_0001);
    chk("t1_cnt_e2", count_o, 1);
    step();
    chk("t1_cnt_e3", count_o, 0);
    chk("t1_nvalid_e3", pop_valid_o, 0);

    // Fill to DEPTH+2 with the consumer stalled, then drain back-to-back.
    pop_ready_i = 1'b0;
    for (int i = 0; i < 18; i++) push_word(i);
    #1;
    chk("t2_ready_full", push_ready_o, 0);
    chk("t2_count_full", count_o, 18);
    step();
    chk("t2_no_read", ram_CEA_o, 0);
    pop_ready_i = 1'b1;
    #1;
    for (int i = 0; i < 18; i++) begin
      chk("t2_valid", pop_valid_o, 1);
      chk("t2_data", pop_data_o, i);
      step();
    end
    chk("t2_empty", count_o, 0);

    // Streaming: one word in RAM, one in flight, one in skid at steady state.
    pop_ready_i = 1'b1;
    for (int k = 0; k < 100; k++) begin
      push_valid_i = 1'b1;
      push_data_i  = 32'h1000 + k;
      #1;
      if (k == 2) chk("t3_count_fill", count_o, 2);
      if (k >= 3) begin
        chk("t3_valid", pop_valid_o, 1);
        chk("t3_data", pop_data_o, 32'h1000 + k - 3);
        chk("t3_count", count_o, 3);
      end
      step();
    end
    push_valid_i = 1'b0;
    drain("t3_drain");

    // Random traffic with backpressure; the compare process checks every cycle.
    for (int k = 0; k < 10000; k++) begin
      push_valid_i = 1'($urandom_range(0, 1));
      push_data_i  = $urandom;
      pop_ready_i  = 1'($urandom_range(0, 1));
      step();
    end
    drain("t4_drain");

    // Wrap-around: 40 words through a 16-deep RAM.
    pop_log.delete();
    pop_ready_i = 1'b1;
    for (int i = 0; i < 40; i++) push_word(32'h500 + i);
    drain("t5_drain");
    chk("t5_len", pop_log.size(), 40);
    if (pop_log.size() == 40) begin
      chk("t5_w15", pop_log[15], 32'h50F);
      chk("t5_w16", pop_log[16], 32'h510);
      chk("t5_w31", pop_log[31], 32'h51F);
      chk("t5_w39", pop_log[39], 32'h527);
    end

    // Reset with count 5 and a read in flight.
    pop_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) push_word(32'h7000 + i);
    pop_ready_i = 1'b1; push_valid_i = 1'b1; push_data_i = 32'h7005;
    #1;
    chk("t6_cea_pre", ram_CEA_o, 1);
    step();
    chk("t6_count5", count_o, 5);
    pop_ready_i = 1'b0; push_valid_i = 1'b0; rst_n = 1'b0;
    step();
    chk("t6_rst_count", count_o, 0);
    chk("t6_rst_valid", pop_valid_o, 0);
    chk("t6_rst_ready", push_ready_o, 0);
    rst_n = 1'b1;
    step();
    step();
    chk("t6_post_valid", pop_valid_o, 0);
    chk("t6_post_count", count_o, 0);
    pop_ready_i = 1'b1; push_valid_i = 1'b1; push_data_i = 32'h6000_0001;
    #1;
    chk("t6_ab0", ram_AB_o, 0);
    step();
    push_valid_i = 1'b0;
    step();
    step();
    chk("t6_new_valid", pop_valid_o, 1);
    chk("t6_new_data", pop_data_o, 32'h6000_0001);
    step();
    chk("t6_final_count", count_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
